// File: rtl/x_ser_pkg.sv
// ---------------------------------------------------------------------------
// x_ser_pkg
// Shared definitions for the x_bit_serializer front end:
//   x_ser_state_e  : FSM state encoding (IDLE, SHIFT)
//   x_ser_head_bit : picks the bit that leaves the shift register next
// ---------------------------------------------------------------------------
package x_ser_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } x_ser_state_e;

   // The word is passed zero-extended to 32 bits so one function serves every
   // WIDTH. i_msb_idx is WIDTH-1 of the caller.
   function automatic logic x_ser_head_bit(input logic [31:0] i_word,
                                           input logic [4:0]  i_msb_idx,
                                           input logic        i_msb_first);
      logic r_bit;
      if (i_msb_first) begin
         r_bit = i_word[i_msb_idx];
      end else begin
         r_bit = i_word[0];
      end
      return r_bit;
   endfunction

endpackage

// File: rtl/x_bit_serializer_counter.sv
// ---------------------------------------------------------------------------
// ser_bit_counter
// Bit-position counter for one frame.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clear : force count to 0 (has priority over i_inc)
//   i_inc   : advance count by one
//   o_count : current bit position, $clog2(WIDTH) bits
//   o_last  : count == WIDTH-1
// ---------------------------------------------------------------------------
module ser_bit_counter
   import x_ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_inc,
   output logic [$clog2(WIDTH)-1:0] o_count,
   output logic                     o_last
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] r_count;

   // Counter register: reset, clear, or increment.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= CW'(0);
      end else if (i_clear) begin
         r_count <= CW'(0);
      end else if (i_inc) begin
         r_count <= r_count + CW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/x_bit_serializer.sv
// ---------------------------------------------------------------------------
// x_bit_serializer
// Parallel-to-serial front end feeding a sequence recognizer's x input.
//   i_clk        : clock, all state changes on the rising edge
//   i_rst        : synchronous active-high reset
//   i_data_in    : WIDTH-bit word, sampled only on a handshake
//   i_data_valid : upstream word available
//   o_data_ready : block accepts a word this cycle (combinational)
//   o_x          : serial bit stream (registered)
//   o_x_valid    : o_x carries a frame bit (registered)
//   o_frame_done : high while the last bit of a word is on o_x (registered)
//   o_busy       : FSM is in SHIFT (registered)
// ---------------------------------------------------------------------------
module x_bit_serializer
   import x_ser_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter logic MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data_in,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   output logic             o_x,
   output logic             o_x_valid,
   output logic             o_frame_done,
   output logic             o_busy
);

   localparam int         CW      = $clog2(WIDTH);
   localparam logic [4:0] MSB_IDX = 5'(WIDTH - 1);

   x_ser_state_e     r_state;
   logic [WIDTH-1:0] r_shreg;
   logic             r_x;
   logic             r_x_valid;
   logic             r_frame_done;
   logic             r_busy;

   logic [CW-1:0]    w_count;
   logic             w_last;
   logic             w_ready;
   logic             w_hs;
   logic             w_in_shift;
   logic [WIDTH-1:0] w_shifted;

   assign w_in_shift = (r_state == ST_SHIFT);

   // Ready in IDLE, or in SHIFT while the final bit of the word goes out,
   // which is what lets words stream without a gap.
   assign w_ready = (r_state == ST_IDLE) ||
                    (w_in_shift && (w_count == CW'(WIDTH - 1)));
   assign w_hs    = i_data_valid && w_ready;

   // Shift toward the head, filling the vacated end with 0.
   assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                : {1'b0, r_shreg[WIDTH-1:1]};

   // Counter restarts on every load and at frame end, so it never passes WIDTH-1.
   ser_bit_counter #(.WIDTH(WIDTH)) u_counter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (w_hs || (w_in_shift && w_last)),
      .i_inc   (w_in_shift),
      .o_count (w_count),
      .o_last  (w_last)
   );

   // Serializer FSM with shift register and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_x          <= IDLE_BIT;
         r_x_valid    <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_x          <= IDLE_BIT;
               r_x_valid    <= 1'b0;
               r_frame_done <= 1'b0;
               if (w_hs) begin
                  r_shreg <= i_data_in;
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
               end else begin
                  r_shreg <= r_shreg;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               r_x          <= x_ser_head_bit(32'(r_shreg), MSB_IDX, MSB_FIRST);
               r_x_valid    <= 1'b1;
               r_frame_done <= w_last;
               if (w_last && w_hs) begin
                  r_shreg <= i_data_in;
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
               end else if (w_last) begin
                  r_shreg <= w_shifted;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_shreg <= w_shifted;
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_shreg      <= '0;
               r_x          <= IDLE_BIT;
               r_x_valid    <= 1'b0;
               r_frame_done <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_data_ready = w_ready;
   assign o_x          = r_x;
   assign o_x_valid    = r_x_valid;
   assign o_frame_done = r_frame_done;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_x_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_x_bit_serializer
// Directed bench for x_bit_serializer. Instance m: WIDTH=8, MSB first,
// idle bit 0. Instance l: WIDTH=8, LSB first, idle bit 1.
// Cycle k is the interval just after rising edge k; edge 0 is the handshake.
// ---------------------------------------------------------------------------
module tb_x_bit_serializer;

   logic       clk = 1'b0;
   int         checks = 0;
   int         failures = 0;

   logic       m_rst, m_valid, m_ready, m_x, m_xv, m_fd, m_busy;
   logic [7:0] m_data;
   logic       l_rst, l_valid, l_ready, l_x, l_xv, l_fd, l_busy;
   logic [7:0] l_data;

   logic [0:7]  exp8;
   logic [0:15] exp16;

   always #5 clk = ~clk;

   x_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .i_clk(clk), .i_rst(m_rst), .i_data_in(m_data), .i_data_valid(m_valid),
      .o_data_ready(m_ready), .o_x(m_x), .o_x_valid(m_xv),
      .o_frame_done(m_fd), .o_busy(m_busy));

   x_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
      .i_clk(clk), .i_rst(l_rst), .i_data_in(l_data), .i_data_valid(l_valid),
      .o_data_ready(l_ready), .o_x(l_x), .o_x_valid(l_xv),
      .o_frame_done(l_fd), .o_busy(l_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      m_rst = 1'b1; m_valid = 1'b0; m_data = 8'h00;
      l_rst = 1'b1; l_valid = 1'b0; l_data = 8'h00;
      tick();
      tick();
      // Reset state
      check("rst_x",     m_x,    1'b0);
      check("rst_xv",    m_xv,   1'b0);
      check("rst_fd",    m_fd,   1'b0);
      check("rst_busy",  m_busy, 1'b0);
      check("rst_l_x",   l_x,    1'b1);
      check("rst_l_busy", l_busy, 1'b0);
      m_rst = 1'b0; l_rst = 1'b0;
      tick();
      check("ready_after_rst", m_ready, 1'b1);

      // Single MSB-first word 8'hA5
      m_data = 8'hA5; m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      check("a5_busy0", m_busy, 1'b1);
      check("a5_ready0", m_ready, 1'b0);
      exp8 = 8'b10100101;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("a5_x",  m_x,  exp8[k]);
         check("a5_xv", m_xv, 1'b1);
         check("a5_fd", m_fd, (k == 7));
      end
      tick();
      check("a5_idle_x",    m_x,    1'b0);
      check("a5_idle_xv",   m_xv,   1'b0);
      check("a5_idle_fd",   m_fd,   1'b0);
      check("a5_idle_busy", m_busy, 1'b0);

      // Back-to-back A5 then 3C, data_valid held until the second handshake
      m_data = 8'hA5; m_valid = 1'b1;
      tick();
      m_data = 8'h3C;
      exp16 = 16'b1010010100111100;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check("b2b_x",  m_x,  exp16[c-1]);
         check("b2b_xv", m_xv, 1'b1);
         check("b2b_fd", m_fd, (c == 8) || (c == 16));
         if (c == 8) m_valid = 1'b0;
      end
      tick();
      check("b2b_end_xv", m_xv, 1'b0);

      // Valid toggling and data changing while not ready: word 8'hC3 unaffected
      m_data = 8'hC3; m_valid = 1'b1;
      tick();
      exp8 = 8'b11000011;
      for (int k = 0; k < 8; k++) begin
         m_valid = (k < 7) ? ((k % 2) == 0) : 1'b0;
         m_data  = 8'h10 + 8'(k * 37);
         tick();
         check("nordy_x",  m_x,  exp8[k]);
         check("nordy_fd", m_fd, (k == 7));
      end
      m_valid = 1'b0;
      tick();
      check("nordy_idle_xv", m_xv, 1'b0);
      tick();
      check("nordy_noextra_xv",   m_xv,   1'b0);
      check("nordy_noextra_busy", m_busy, 1'b0);

      // Reset mid-frame of 8'hFF, asserted in cycle 4
      m_data = 8'hFF; m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("midrst_x", m_x, 1'b1);
      end
      m_rst = 1'b1;
      tick();
      m_rst = 1'b0;
      check("midrst_x_idle", m_x,    1'b0);
      check("midrst_xv",     m_xv,   1'b0);
      check("midrst_busy",   m_busy, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("midrst_nofd", m_fd, 1'b0);
         check("midrst_noxv", m_xv, 1'b0);
      end
      m_data = 8'h80; m_valid = 1'b1;
      tick();
      m_valid = 1'b0;
      exp8 = 8'b10000000;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("w80_x",  m_x,  exp8[k]);
         check("w80_xv", m_xv, 1'b1);
         check("w80_fd", m_fd, (k == 7));
      end
      tick();
      check("w80_idle_xv", m_xv, 1'b0);

      // Reset priority over a handshake
      m_rst = 1'b1; m_valid = 1'b1; m_data = 8'h5A;
      tick();
      m_rst = 1'b0; m_valid = 1'b0;
      check("rstpri_busy", m_busy, 1'b0);
      check("rstpri_xv",   m_xv,   1'b0);
      tick();
      check("rstpri_xv_next",   m_xv,   1'b0);
      check("rstpri_busy_next", m_busy, 1'b0);
      check("rstpri_x_next",    m_x,    1'b0);

      // LSB-first word 8'h01, idle bit 1
      check("lsb_ready_idle", l_ready, 1'b1);
      l_data = 8'h01; l_valid = 1'b1;
      tick();
      l_valid = 1'b0;
      check("lsb_ready_c0", l_ready, 1'b0);
      exp8 = 8'b10000000;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("lsb_x",     l_x,     exp8[k]);
         check("lsb_xv",    l_xv,    1'b1);
         check("lsb_fd",    l_fd,    (k == 7));
         check("lsb_ready", l_ready, (k >= 6));
      end
      tick();
      check("lsb_idle_x",  l_x,  1'b1);
      check("lsb_idle_xv", l_xv, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
